// File: rtl/pc_sequencer_if.sv
// Bundle between the control decoder / datapath (master) and the next-PC stage (slave).
// Carries branch/jump strobes, operands and the PC, flag and link results.
interface pc_sequencer_if;
    logic        stall;
    logic        branch;
    logic        baln;
    logic        bgtzal;
    logic        jrsal;
    logic        jmnor;
    logic        zero;
    logic        alu_neg;
    logic        flag_we;
    logic [31:0] rs_data;
    logic [31:0] imm_ext;
    logic [31:0] jmnor_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        nsignal_q;
    logic        link_we;
    logic [31:0] link_data;
    logic [2:0]  pc_src;
    logic [31:0] instr_count;

    modport master (
        output stall, branch, baln, bgtzal, jrsal, jmnor, zero, alu_neg, flag_we,
               rs_data, imm_ext, jmnor_target,
        input  pc, pc_plus4, nsignal_q, link_we, link_data, pc_src, instr_count
    );

    modport slave (
        input  stall, branch, baln, bgtzal, jrsal, jmnor, zero, alu_neg, flag_we,
               rs_data, imm_ext, jmnor_target,
        output pc, pc_plus4, nsignal_q, link_we, link_data, pc_src, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC and N-flag stage: selects the next PC from the decoded branch/jump strobes,
// holds PC, N flag and retired-cycle counter, and generates the $31 link write.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_BALN   = 3'd2,
        SRC_BGTZAL = 3'd3,
        SRC_JRSAL  = 3'd4,
        SRC_JMNOR  = 3'd5
    } src_e;

    logic [DATA_W-1:0]        pc_q;
    logic                     n_q;
    logic [DATA_W-1:0]        cnt_q;
    logic [DATA_W-1:0]        pc_plus4;
    logic [DATA_W-1:0]        btarget;
    logic [DATA_W-1:0]        next_pc;
    logic signed [DATA_W-1:0] rs_s;
    logic                     rs_pos;
    src_e                     win;
    logic                     win_taken;
    src_e                     src;

    assign pc_plus4 = pc_q + 32'd4;
    assign btarget  = pc_plus4 + {bus.imm_ext[DATA_W-3:0], 2'b00};
    assign rs_s     = bus.rs_data;
    assign rs_pos   = rs_s > 0;

    // Only the highest-priority strobe is considered; if it is not taken we
    // fall through to sequential rather than trying a lower-priority source.
    always_comb begin
        win       = SRC_SEQ;
        win_taken = 1'b0;
        if (bus.jmnor) begin
            win       = SRC_JMNOR;
            win_taken = 1'b1;
        end else if (bus.jrsal) begin
            win       = SRC_JRSAL;
            win_taken = 1'b1;
        end else if (bus.baln) begin
            win       = SRC_BALN;
            win_taken = n_q;
        end else if (bus.bgtzal) begin
            win       = SRC_BGTZAL;
            win_taken = rs_pos;
        end else if (bus.branch) begin
            win       = SRC_BRANCH;
            win_taken = bus.zero;
        end
        src = win_taken ? win : SRC_SEQ;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (src)
            SRC_BRANCH, SRC_BALN, SRC_BGTZAL: next_pc = btarget;
            SRC_JRSAL:                        next_pc = {bus.rs_data[DATA_W-1:2], 2'b00};
            SRC_JMNOR:                        next_pc = {bus.jmnor_target[DATA_W-1:2], 2'b00};
            default:                          next_pc = pc_plus4;
        endcase
    end

    // State registers; baln above reads n_q before this edge updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            n_q   <= 1'b0;
            cnt_q <= '0;
        end else if (!bus.stall) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + 32'd1;
            if (bus.flag_we) begin
                n_q <= bus.alu_neg;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.nsignal_q   = n_q;
    assign bus.instr_count = cnt_q;
    assign bus.pc_src      = src;
    assign bus.link_data   = pc_plus4;
    assign bus.link_we     = !bus.stall && !reset &&
                             (src == SRC_JRSAL || src == SRC_BALN || src == SRC_BGTZAL);
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table for the documented corner cases,
// then constrained-random cycles against a priority-list reference model.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall, branch, baln, bgtzal, jrsal, jmnor, zero, alu_neg, flag_we;
        logic [31:0] rs, imm, jt;
        logic [2:0]  e_src;
        bit          e_link;
        logic [31:0] e_ld, e_pc;
        bit          e_n;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit br, input bit bl, input bit bg, input bit jr,
                         input bit jm, input bit z, input bit an, input bit fw,
                         input logic [31:0] rs, input logic [31:0] imm, input logic [31:0] jt);
        bus.stall = st; bus.branch = br; bus.baln = bl; bus.bgtzal = bg;
        bus.jrsal = jr; bus.jmnor = jm; bus.zero = z; bus.alu_neg = an; bus.flag_we = fw;
        bus.rs_data = rs; bus.imm_ext = imm; bus.jmnor_target = jt;
    endtask

    // Reference: candidates listed in priority order; the first raised strobe decides.
    logic [31:0] m_pc, m_cnt;
    bit          m_n;

    task automatic model(output logic [2:0] e_src, output bit e_link, output logic [31:0] e_next);
        bit          req[5];
        bit          tk[5];
        bit          lk[5];
        logic [31:0] tgt[5];
        int          code[5];
        int signed   rs_val;
        logic [31:0] seq, bt;
        seq    = m_pc + 32'd4;
        bt     = seq + bus.imm_ext * 32'd4;
        rs_val = bus.rs_data;
        req  = '{bus.jmnor, bus.jrsal, bus.baln, bus.bgtzal, bus.branch};
        tk   = '{1'b1, 1'b1, m_n, rs_val > 0, bus.zero};
        lk   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tgt  = '{bus.jmnor_target & ~32'd3, bus.rs_data & ~32'd3, bt, bt, bt};
        code = '{5, 4, 2, 3, 1};
        e_src = 3'd0; e_link = 1'b0; e_next = seq;
        for (int i = 0; i < 5; i++) begin
            if (req[i]) begin
                if (tk[i]) begin
                    e_src  = 3'(code[i]);
                    e_link = lk[i] && !bus.stall;
                    e_next = tgt[i];
                end
                break;
            end
        end
    endtask

    initial begin
        logic [2:0]  e_src;
        bit          e_link;
        logic [31:0] e_next;
        logic [31:0] cnt_exp;
        logic [15:0] r16;

        vecs[0]  = '{0,0,0,0,1,0,0,0,0, 32'h100, 32'h0, 32'h0, 3'd4,1, 32'h0040_0010, 32'h100, 0};
        vecs[1]  = '{0,1,0,0,0,0,1,0,0, 32'h0, 32'hFFFF_FFFF, 32'h0, 3'd1,0, 32'h104, 32'h100, 0};
        vecs[2]  = '{0,1,0,0,0,0,0,0,0, 32'h0, 32'hFFFF_FFFF, 32'h0, 3'd0,0, 32'h104, 32'h104, 0};
        vecs[3]  = '{0,0,0,0,1,0,0,1,1, 32'h200, 32'h0, 32'h0, 3'd4,1, 32'h108, 32'h200, 1};
        vecs[4]  = '{0,0,1,0,0,0,0,0,0, 32'h0, 32'h4, 32'h0, 3'd2,1, 32'h204, 32'h214, 1};
        vecs[5]  = '{0,0,0,0,0,0,0,0,1, 32'h0, 32'h0, 32'h0, 3'd0,0, 32'h218, 32'h218, 0};
        vecs[6]  = '{0,0,0,0,1,0,0,0,0, 32'h200, 32'h0, 32'h0, 3'd4,1, 32'h21C, 32'h200, 0};
        vecs[7]  = '{0,0,1,0,0,0,0,1,1, 32'h0, 32'h4, 32'h0, 3'd0,0, 32'h204, 32'h204, 1};
        vecs[8]  = '{0,0,0,1,0,0,0,0,0, 32'h1, 32'h8, 32'h0, 3'd3,1, 32'h208, 32'h228, 1};
        vecs[9]  = '{0,0,0,1,0,0,0,0,0, 32'h0, 32'h8, 32'h0, 3'd0,0, 32'h22C, 32'h22C, 1};
        vecs[10] = '{0,0,0,1,0,0,0,0,0, 32'h8000_0000, 32'h8, 32'h0, 3'd0,0, 32'h230, 32'h230, 1};
        vecs[11] = '{0,0,0,0,1,0,0,0,0, 32'h1003, 32'h0, 32'h0, 3'd4,1, 32'h234, 32'h1000, 1};
        vecs[12] = '{0,0,0,0,0,1,0,0,0, 32'h0, 32'h0, 32'h2000, 3'd5,0, 32'h1004, 32'h2000, 1};
        vecs[13] = '{0,0,0,0,1,1,0,0,0, 32'h500, 32'h0, 32'h3001, 3'd5,0, 32'h2004, 32'h3000, 1};
        vecs[14] = '{1,0,0,0,1,0,0,0,1, 32'h40, 32'h0, 32'h0, 3'd4,0, 32'h3004, 32'h3000, 1};
        vecs[15] = '{0,0,0,0,1,0,0,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd4,1, 32'h3004, 32'hFFFF_FFFC, 1};
        vecs[16] = '{0,0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 3'd0,0, 32'h0, 32'h0, 1};
        vecs[17] = '{0,1,1,0,0,0,1,0,0, 32'h0, 32'h2, 32'h0, 3'd2,1, 32'h4, 32'hC, 1};
        vecs[18] = '{0,1,0,1,0,0,1,0,0, 32'h0, 32'h0, 32'h0, 3'd0,0, 32'h10, 32'h10, 1};

        drive(0,0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);

        // Asynchronous reset mid-cycle, with a jrsal strobe up to confirm link suppression
        @(negedge clk);
        bus.jrsal = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_n", 32'(bus.nsignal_q), 32'd0);
        chk("rst_cnt", bus.instr_count, 32'd0);
        chk("rst_link_we", 32'(bus.link_we), 32'd0);
        bus.jrsal = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle3_pc", bus.pc, 32'h0040_000C);
        chk("idle3_cnt", bus.instr_count, 32'd3);

        cnt_exp = 32'd3;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].branch, vecs[i].baln, vecs[i].bgtzal, vecs[i].jrsal,
                  vecs[i].jmnor, vecs[i].zero, vecs[i].alu_neg, vecs[i].flag_we,
                  vecs[i].rs, vecs[i].imm, vecs[i].jt);
            #1;
            chk($sformatf("v%0d_src", i), 32'(bus.pc_src), 32'(vecs[i].e_src));
            chk($sformatf("v%0d_link_we", i), 32'(bus.link_we), 32'(vecs[i].e_link));
            chk($sformatf("v%0d_link_data", i), bus.link_data, vecs[i].e_ld);
            chk($sformatf("v%0d_pc_plus4", i), bus.pc_plus4, vecs[i].e_ld);
            @(posedge clk);
            #1;
            if (!vecs[i].stall) cnt_exp = cnt_exp + 32'd1;
            chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].e_pc);
            chk($sformatf("v%0d_n", i), 32'(bus.nsignal_q), 32'(vecs[i].e_n));
            chk($sformatf("v%0d_cnt", i), bus.instr_count, cnt_exp);
        end
        chk("table_cnt", bus.instr_count, 32'd21);

        m_pc = 32'h10; m_n = 1'b1; m_cnt = 32'd21;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            r16 = 16'($urandom);
            bus.stall   = ($urandom_range(0, 7) == 0);
            bus.branch  = ($urandom_range(0, 3) == 0);
            bus.baln    = ($urandom_range(0, 3) == 0);
            bus.bgtzal  = ($urandom_range(0, 3) == 0);
            bus.jrsal   = ($urandom_range(0, 5) == 0);
            bus.jmnor   = ($urandom_range(0, 5) == 0);
            bus.zero    = 1'($urandom);
            bus.alu_neg = 1'($urandom);
            bus.flag_we = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.rs_data = 32'h0;
                1:       bus.rs_data = 32'($urandom_range(1, 4096));
                2:       bus.rs_data = 32'h8000_0000 | $urandom;
                default: bus.rs_data = $urandom;
            endcase
            bus.imm_ext      = {{16{r16[15]}}, r16};
            bus.jmnor_target = $urandom;
            #1;
            model(e_src, e_link, e_next);
            chk("rnd_src", 32'(bus.pc_src), 32'(e_src));
            chk("rnd_link_we", 32'(bus.link_we), 32'(e_link));
            chk("rnd_link_data", bus.link_data, m_pc + 32'd4);
            if (!bus.stall) begin
                m_pc  = e_next;
                m_cnt = m_cnt + 32'd1;
                if (bus.flag_we) m_n = bus.alu_neg;
            end
            @(posedge clk);
            #1;
            chk("rnd_pc", bus.pc, m_pc);
            chk("rnd_n", 32'(bus.nsignal_q), 32'(m_n));
            chk("rnd_cnt", bus.instr_count, m_cnt);
        end

        // Reset wins over stall and holds across an edge
        @(negedge clk);
        drive(1,0,0,0,1,0,0,1,1, 32'h44, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("rst2_pc", bus.pc, RST_PC);
        chk("rst2_cnt", bus.instr_count, 32'd0);
        chk("rst2_n", 32'(bus.nsignal_q), 32'd0);
        chk("rst2_link_we", 32'(bus.link_we), 32'd0);
        @(posedge clk);
        #1;
        chk("rst2_hold_pc", bus.pc, RST_PC);
        @(negedge clk);
        reset = 1'b0;
        drive(0,0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_pc", bus.pc, RST_PC + 32'd4);
        chk("post_rst_cnt", bus.instr_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC and status-flag stage of the single-cycle datapath. It consumes the decoded branch/jump strobes from the main control decoder, holds the program counter and the N status flag, and produces the link write for `$31`. Its `nsignal_q` output is the registered N flag, and the control decoder takes that flag as an input.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `stall`, input, 1: freezes all state for the cycle.
- `branch`, input, 1: beq strobe from the control decoder.
- `baln`, input, 1: branch-and-link-if-negative strobe.
- `bgtzal`, input, 1: branch-if-greater-than-zero-and-link strobe.
- `jrsal`, input, 1: jump-register-and-link strobe.
- `jmnor`, input, 1: jump-via-memory strobe, already funct-qualified upstream.
- `zero`, input, 1: ALU zero flag for the current instruction.
- `alu_neg`, input, 1: bit 31 of the current ALU result.
- `flag_we`, input, 1: capture `alu_neg` into the N flag.
- `rs_data`, input, 32: register-file rs read value.
- `imm_ext`, input, 32: sign-extended 16-bit immediate.
- `jmnor_target`, input, 32: data-memory read word at address (rs NOR rt).
- `pc`, output, 32: current PC, registered.
- `pc_plus4`, output, 32: `pc + 4`, combinational.
- `nsignal_q`, output, 1: registered N flag.
- `link_we`, output, 1: write `$31` this cycle.
- `link_data`, output, 32: value for `$31`; always equals `pc_plus4`.
- `pc_src`, output, 3: selected source (0 seq, 1 branch, 2 baln, 3 bgtzal, 4 jrsal, 5 jmnor); observability only.
- `instr_count`, output, 32: count of non-stalled cycles since reset.

## Operation
- **Sequential next PC:** `pc_plus4 = pc + 4`. Addition is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- **Branch target:** `btarget = pc_plus4 + (imm_ext << 2)`, modulo 2^32.
- **Jump targets:** for `jrsal` and `jmnor`, the target is `rs_data` and `jmnor_target` respectively, with bits [1:0] forced to 0.
- **Taken conditions:**
  - branch: `branch & zero`.
  - baln: `baln & nsignal_q`. Uses the registered flag, i.e. the value from before this cycle's update.
  - bgtzal: `bgtzal & ($signed(rs_data) > 0)`. An `rs_data` of 0 or any negative value is not taken.
  - jrsal and jmnor: always taken.
- **Priority** if more than one strobe is high (illegal decode): jmnor > jrsal > baln > bgtzal > branch. Only the winner affects `pc_src` and `link_we`.
- **next_pc:**
  - target of the highest-priority taken source;
  - otherwise `pc_plus4`. A not-taken strobe falls through to sequential; a lower-priority taken strobe is not substituted.
- **Link:**
  - `link_we` = winner is jrsal, OR winner is baln and taken, OR winner is bgtzal and taken.
  - jmnor and beq never link.
  - `link_we` is forced to 0 while `stall` or `reset` is high.
- **N flag:** on a non-stalled edge with `flag_we=1`, `nsignal_q <= alu_neg`; otherwise it holds. When `baln` and `flag_we` are high in the same cycle, the branch decision uses the old flag and the flag still updates.
- **`pc_src`** reports the winning source when it is taken, else 0.

## Timing
- **Reset:**
  - Asynchronous, effective immediately, with no clock required.
  - Values: `pc=RESET_PC`, `nsignal_q=0`, `instr_count=0`, `link_we=0`. `pc_plus4` and `pc_src` follow combinationally from `pc`.
  - Reset takes precedence over `stall`. Deasserting reset mid-cycle has no effect until the next rising edge.
- **Normal cycle:**
  - All next-state and link decisions are combinational from the current inputs and registers.
  - `pc`, `nsignal_q` and `instr_count` update on the rising edge; latency is exactly 1 cycle.
- **Stall:** `pc`, `nsignal_q` and `instr_count` hold, `link_we=0`, and `pc_src` still reports the would-be selection.
- **Counter:** `instr_count` increments by 1 on every non-stalled, non-reset edge and wraps from `32'hFFFF_FFFF` to 0.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with `RESET_PC=32'h0040_0000` -> `pc=32'h0040_0000`, `nsignal_q=0`, `instr_count=0` before any edge. Then 3 idle edges -> `pc=32'h0040_000C`, `instr_count=3`.
- **beq:** `pc=32'h100`, `branch=1`, `imm_ext=32'hFFFF_FFFF`.
  - With `zero=1` -> next `pc=32'h100`, `pc_src=1`, `link_we=0`.
  - With `zero=0` -> next `pc=32'h104`.
- **baln and flag ordering:**
  - `flag_we=1`, `alu_neg=1` -> `nsignal_q=1`.
  - Next cycle, `baln=1`, `imm_ext=4`, `pc=32'h200` -> `pc=32'h214`, `link_we=1`, `link_data=32'h204`.
  - Same-cycle `baln` with `flag_we` setting N from 0 -> not taken, `pc=32'h204`, and the flag becomes 1.
- **bgtzal signed compare:**
  - `rs_data=1` -> taken, with link.
  - `rs_data=0` or `32'h8000_0000` -> `pc=pc+4`, `link_we=0`.
- **Jumps:**
  - `jrsal` with `rs_data=32'h0000_1003` -> `pc=32'h1000`, `link_we=1`.
  - `jmnor` with `jmnor_target=32'h2000` -> `pc=32'h2000`, `link_we=0`.
  - `jmnor` and `jrsal` together -> jmnor wins, `pc_src=5`.
- **Stall and wrap:**
  - `stall=1` with `jrsal` -> `pc`, `instr_count` and `nsignal_q` unchanged, `link_we=0`.
  - `pc=32'hFFFF_FFFC`, sequential -> `pc=0`.
